// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
//   Shared definitions for the parallel-in/serial-out transmitter.
//   - piso_state_t     : FSM state encoding (IDLE, SHIFT, PARITY)
//   - PARITY_BITS      : 1 when the even-parity trailer is built in, else 0
//   - piso_frame_len   : serial frame length in cycles for a given data width
//   - piso_count_width : bit-counter width needed to index a frame
//
//   Optional feature macro: PISO_PARITY_EN
//     defined   -> one even-parity bit follows the data bits of every frame
//     undefined -> frames carry data bits only
// -----------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;

`ifdef PISO_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Number of serial cycles a single word occupies on the link.
    function automatic int piso_frame_len(input int width);
        return width + PARITY_BITS;
    endfunction

    // The counter must be able to hold every index 0 .. frame_len-1.
    function automatic int piso_count_width(input int frame_len);
        return (frame_len <= 2) ? 1 : $clog2(frame_len);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// -----------------------------------------------------------------------------
// piso_bit_counter
//   Index of the frame bit currently presented on the serial output.
//   Cleared when a word is accepted, advanced once per transmitted bit, and
//   held at the terminal index once the last frame bit has been reached so it
//   never free-runs while the transmitter sits idle.
//
// Ports
//   clk       in   1    clock, updates on posedge
//   rst_n     in   1    asynchronous active-low reset (count -> 0)
//   clear     in   1    load 0 (has priority over enable)
//   enable    in   1    advance to the next bit index
//   count     out  CW   current bit index
//   terminal  out  1    count equals FRAME_LEN-1 (final bit of the frame)
// -----------------------------------------------------------------------------
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int FRAME_LEN = 4,
    parameter int CW        = piso_count_width(FRAME_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          terminal
);

    localparam logic [CW-1:0] TERMINAL_IDX = CW'(FRAME_LEN - 1);

    // Clear wins so a back-to-back accept on the final bit restarts at 0;
    // otherwise saturate at the terminal index rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TERMINAL_IDX)) begin
            count <= count + CW'(1);
        end
    end

    assign terminal = (count == TERMINAL_IDX);

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in/serial-out transmitter. A WIDTH-bit word is accepted on a
//   valid/ready handshake and then shifted out one bit per clock, with a
//   bit-valid qualifier and a start-of-frame marker on the first bit. The
//   transmitter re-arms on the final bit of a frame so words can be streamed
//   with no idle gap between frames.
//
// Parameters
//   WIDTH      data bits per frame (>= 2)
//   MSB_FIRST  1: a[WIDTH-1] goes out first; 0: a[0] goes out first
//
// Ports
//   clk         in   1      clock, all state updates on posedge
//   rst_n       in   1      asynchronous active-low reset
//   a           in   WIDTH  parallel word to transmit
//   load_valid  in   1      a is valid this cycle
//   load_ready  out  1      word is accepted at this posedge if load_valid=1
//   sout        out  1      serial data bit
//   sout_valid  out  1      sout carries a frame bit this cycle
//   sof         out  1      high with the first bit of each frame
//
// Optional feature macro: PISO_PARITY_EN
//   When defined, an even-parity bit (XOR of the data bits) is sent after the
//   last data bit and the handshake re-arms on that parity cycle instead.
// -----------------------------------------------------------------------------
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof
);

    localparam int FRAME_LEN = piso_frame_len(WIDTH);
    localparam int CW        = piso_count_width(FRAME_LEN);

    piso_state_t      state;
    piso_state_t      state_next;

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_adv;
    logic             a_head;
    logic             adv_head;

    logic [CW-1:0]    bit_count;
    logic             terminal;

    logic             accept;
    logic             cnt_clear;
    logic             cnt_enable;
    logic             capture;
    logic             advance;

    logic             sout_next;
    logic             sout_valid_next;
    logic             sof_next;

`ifdef PISO_PARITY_EN
    localparam logic [CW-1:0] LAST_DATA_IDX = CW'(WIDTH - 1);
    logic             parity_reg;
    logic             last_data;

    assign last_data = (bit_count == LAST_DATA_IDX);
`endif

    // The shift register always holds the bit on sout at its head; shift_adv
    // is the register after dropping that bit, so its head is the next bit.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shift_adv = {shift_reg[WIDTH-2:0], 1'b0};
            a_head    = a[WIDTH-1];
            adv_head  = shift_adv[WIDTH-1];
        end else begin
            shift_adv = {1'b0, shift_reg[WIDTH-1:1]};
            a_head    = a[0];
            adv_head  = shift_adv[0];
        end
    end

    piso_bit_counter #(
        .FRAME_LEN (FRAME_LEN),
        .CW        (CW)
    ) u_bit_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .count    (bit_count),
        .terminal (terminal)
    );

    // Ready while idle and on the final cycle of a frame; the counter sits at
    // its terminal index exactly on that final cycle.
    always_comb begin
        load_ready = 1'b0;
        case (state)
            IDLE:    load_ready = 1'b1;
`ifdef PISO_PARITY_EN
            SHIFT:   load_ready = 1'b0;
            PARITY:  load_ready = terminal;
`else
            SHIFT:   load_ready = terminal;
`endif
            default: load_ready = 1'b0;
        endcase
    end

    assign accept = load_valid & load_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output decode. An accept can only happen when the
    // current cycle is idle or the last cycle of a frame, so it simply takes
    // over whatever the frame-ending branch decided.
    always_comb begin
        state_next      = state;
        cnt_clear       = 1'b0;
        cnt_enable      = 1'b0;
        capture         = 1'b0;
        advance         = 1'b0;
        sout_next       = 1'b0;
        sout_valid_next = 1'b0;
        sof_next        = 1'b0;

        case (state)
            IDLE: begin
                state_next = IDLE;
            end
            SHIFT: begin
`ifdef PISO_PARITY_EN
                if (!last_data) begin
                    cnt_enable      = 1'b1;
                    advance         = 1'b1;
                    sout_next       = adv_head;
                    sout_valid_next = 1'b1;
                end else begin
                    state_next      = PARITY;
                    cnt_enable      = 1'b1;
                    sout_next       = parity_reg;
                    sout_valid_next = 1'b1;
                end
`else
                if (!terminal) begin
                    cnt_enable      = 1'b1;
                    advance         = 1'b1;
                    sout_next       = adv_head;
                    sout_valid_next = 1'b1;
                end else begin
                    state_next = IDLE;
                end
`endif
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_next = IDLE;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase

        if (accept) begin
            state_next      = SHIFT;
            cnt_clear       = 1'b1;
            cnt_enable      = 1'b0;
            capture         = 1'b1;
            advance         = 1'b0;
            sout_next       = a_head;
            sout_valid_next = 1'b1;
            sof_next        = 1'b1;
        end
    end

    // Datapath and registered outputs. Capturing the word here means later
    // changes on a cannot disturb the frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sof        <= 1'b0;
        end else begin
            if (capture) begin
                shift_reg <= a;
            end else if (advance) begin
                shift_reg <= shift_adv;
            end
            sout       <= sout_next;
            sout_valid <= sout_valid_next;
            sof        <= sof_next;
        end
    end

`ifdef PISO_PARITY_EN
    // Parity is fixed at accept time so it always matches the captured word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_reg <= 1'b0;
        end else if (capture) begin
            parity_reg <= ^a;
        end
    end
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Drives an MSB-first and an LSB-first piso_serializer from the same inputs
//   and compares both against a queue-based frame model: an accepted word
//   becomes a list of frame bits, one popped per clock. Honours PISO_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic             load_valid;

    logic ready_m, sout_m, valid_m, sof_m;
    logic ready_l, sout_l, valid_l, sof_l;

    int checks;
    int errors;

    // Model: current bit on the link plus the bits still to come.
    bit q_m[$];
    bit q_l[$];
    bit cur_valid;
    bit cur_sof;
    bit cur_m;
    bit cur_l;

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .load_valid (load_valid),
        .load_ready (ready_m),
        .sout       (sout_m),
        .sout_valid (valid_m),
        .sof        (sof_m)
    );

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .load_valid (load_valid),
        .load_ready (ready_l),
        .sout       (sout_l),
        .sout_valid (valid_l),
        .sof        (sof_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ready when nothing is on the link or the bit on the link is the last one.
    function automatic bit expReady();
        return (!cur_valid) || (q_m.size() == 0);
    endfunction

    task automatic modelReset();
        q_m.delete();
        q_l.delete();
        cur_valid = 1'b0;
        cur_sof   = 1'b0;
        cur_m     = 1'b0;
        cur_l     = 1'b0;
    endtask

    task automatic modelLoad(input logic [WIDTH-1:0] w);
        q_m.delete();
        q_l.delete();
        for (int i = WIDTH - 1; i >= 0; i--) q_m.push_back(w[i]);
        for (int i = 0; i < WIDTH; i++) q_l.push_back(w[i]);
`ifdef PISO_PARITY_EN
        q_m.push_back(^w);
        q_l.push_back(^w);
`endif
        cur_m     = q_m.pop_front();
        cur_l     = q_l.pop_front();
        cur_valid = 1'b1;
        cur_sof   = 1'b1;
    endtask

    task automatic modelAdvance(input bit accepted, input logic [WIDTH-1:0] w);
        if (accepted) begin
            modelLoad(w);
        end else if (q_m.size() > 0) begin
            cur_m   = q_m.pop_front();
            cur_l   = q_l.pop_front();
            cur_sof = 1'b0;
        end else begin
            modelReset();
        end
    endtask

    task automatic checkBit(input string tag, input string name, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s %s: observed %0b expected %0b", tag, name, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkBit(tag, "sout_msb",   sout_m,  cur_m);
        checkBit(tag, "sout_lsb",   sout_l,  cur_l);
        checkBit(tag, "valid_msb",  valid_m, cur_valid);
        checkBit(tag, "valid_lsb",  valid_l, cur_valid);
        checkBit(tag, "sof_msb",    sof_m,   cur_sof);
        checkBit(tag, "sof_lsb",    sof_l,   cur_sof);
        checkBit(tag, "ready_msb",  ready_m, expReady());
        checkBit(tag, "ready_lsb",  ready_l, expReady());
    endtask

    // One clock of stimulus: inputs change just after a posedge and outputs
    // are compared 1 time unit after the following posedge.
    task automatic applyStimulus(input string tag, input bit v, input logic [WIDTH-1:0] w);
        bit accepted;
        accepted   = v && expReady();
        load_valid = v;
        a          = w;
        @(posedge clk);
        #1;
        modelAdvance(accepted, w);
        checkOutput(tag);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        a          = '0;
        modelReset();
        #3;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single frame 1110");
        applyStimulus("frame1110", 1'b1, 4'b1110);
        for (int i = 0; i < WIDTH + 2; i++)
            applyStimulus("frame1110", 1'b0, 4'($urandom));

        $display("[TB] back-to-back 1110 then 0001");
        applyStimulus("b2b", 1'b1, 4'b1110);
        for (int i = 0; i < WIDTH; i++)
            applyStimulus("b2b", 1'b1, 4'b0001);
        for (int i = 0; i < WIDTH + 2; i++)
            applyStimulus("b2b", 1'b0, 4'($urandom));

        $display("[TB] load pulse while busy");
        applyStimulus("busy", 1'b1, 4'b1110);
        applyStimulus("busy", 1'b0, 4'b0000);
        applyStimulus("busy", 1'b1, 4'b0101);
        for (int i = 0; i < WIDTH + 1; i++)
            applyStimulus("busy", 1'b0, 4'($urandom));

        $display("[TB] asynchronous reset mid-frame");
        applyStimulus("midreset", 1'b1, 4'b1110);
        applyStimulus("midreset", 1'b0, 4'b0000);
        #1;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("after_reset", 1'b0, 4'b0000);
        applyStimulus("after_reset", 1'b1, 4'b1001);
        for (int i = 0; i < WIDTH + 1; i++)
            applyStimulus("after_reset", 1'b0, 4'($urandom));

        $display("[TB] randomized traffic");
        for (int i = 0; i < 300; i++)
            applyStimulus("random", ($urandom_range(0, 99) < 60), 4'($urandom));
        for (int i = 0; i < WIDTH + 2; i++)
            applyStimulus("drain", 1'b0, 4'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
